// File: rtl/frame_stream_pkg.sv
// Shared types, default raster timing and the pixel pattern function for the frame stream generator.
package frame_stream_pkg;

    localparam int unsigned CntW       = 16;
    localparam int unsigned DefHActive = 800;
    localparam int unsigned DefHBlank  = 100;
    localparam int unsigned DefVActive = 600;
    localparam int unsigned DefVBlank  = 100;

    typedef enum logic [1:0] {
        PatConst   = 2'd0,
        PatHRamp   = 2'd1,
        PatVRamp   = 2'd2,
        PatChecker = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    typedef struct packed {
        pattern_e   pattern;
        logic [7:0] const_val;
    } pix_cfg_t;

    function automatic logic [7:0] pixel_value(pix_cfg_t cfg, logic [7:0] x, logic [7:0] y);
        logic [7:0] val;
        val = cfg.const_val;
        case (cfg.pattern)
            PatConst:   val = cfg.const_val;
            PatHRamp:   val = x;
            PatVRamp:   val = y;
            PatChecker: val = (x[4] ^ y[4]) ? 8'hFF : 8'h00;
            default:    val = cfg.const_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/frame_stream_gen_if.sv
// Control and pixel-stream bundle; master is the generator side, slave the consumer/controller.
interface frame_stream_gen_if;
    logic       start;
    logic       stop;
    logic [7:0] num_frames;
    logic [1:0] pattern_sel;
    logic [7:0] const_val;
    logic [7:0] dout;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       frame_done;
    logic       busy;
    logic [7:0] frame_count;

    modport master (
        input  start, stop, num_frames, pattern_sel, const_val,
        output dout, valid, sof, eol, frame_done, busy, frame_count
    );

    modport slave (
        output start, stop, num_frames, pattern_sel, const_val,
        input  dout, valid, sof, eol, frame_done, busy, frame_count
    );
endinterface

// File: rtl/raster_counter.sv
// x/y raster position counter; x wraps at HTotal, y advances on each x wrap and wraps at VTotal.
module raster_counter
    import frame_stream_pkg::*;
#(
    parameter int unsigned HTotal = DefHActive + DefHBlank,
    parameter int unsigned VTotal = DefVActive + DefVBlank
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [CntW-1:0] x,
    output logic [CntW-1:0] y,
    output logic            eof
);

    logic [CntW-1:0] x_q, x_d;
    logic [CntW-1:0] y_q, y_d;
    logic            x_last, y_last;

    assign x_last = (x_q == CntW'(HTotal - 1));
    assign y_last = (y_q == CntW'(VTotal - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (enable) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x   = x_q;
    assign y   = y_q;
    assign eof = x_last && y_last;

endmodule

// File: rtl/frame_stream_gen.sv
// Test-pattern video frame generator: raster counter, IDLE/RUN/DRAIN control and a registered
// pixel output stage that lags the counters by one cycle.
module frame_stream_gen
    import frame_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_BLANK  = DefHBlank,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_BLANK  = DefVBlank
) (
    input logic                clock,
    input logic                reset,
    frame_stream_gen_if.master bus
);

    localparam logic [CntW-1:0] HActW    = CntW'(H_ACTIVE);
    localparam logic [CntW-1:0] HActLast = CntW'(H_ACTIVE - 1);
    localparam logic [CntW-1:0] VActW    = CntW'(V_ACTIVE);

    state_e          state_q, state_d;
    logic [CntW-1:0] x, y;
    logic            eof;
    logic            running, start_acc, final_frame, active;

    pix_cfg_t   cfg_q, cfg_d;
    logic [7:0] num_frames_q, num_frames_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       sof_q, sof_d;
    logic       eol_q, eol_d;
    logic       frame_done_q, frame_done_d;
    logic       busy_q, busy_d;

    assign running     = (state_q != StIdle);
    assign start_acc   = (state_q == StIdle) && bus.start;
    assign final_frame = (num_frames_q != 8'd0) && (frame_count_q + 8'd1 == num_frames_q);

    raster_counter #(
        .HTotal(H_ACTIVE + H_BLANK),
        .VTotal(V_ACTIVE + V_BLANK)
    ) u_raster (
        .clock (clock),
        .reset (reset),
        .clear (start_acc),
        .enable(running),
        .x     (x),
        .y     (y),
        .eof   (eof)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun: begin
                // A stop that lands on the last cycle of a frame has nothing left to drain.
                if (eof && (final_frame || bus.stop)) state_d = StIdle;
                else if (bus.stop)                    state_d = StDrain;
            end
            StDrain: if (eof) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active        = running && (x < HActW) && (y < VActW);
        valid_d       = active;
        dout_d        = active ? pixel_value(cfg_q, x[7:0], y[7:0]) : 8'd0;
        sof_d         = active && (x == '0) && (y == '0);
        eol_d         = active && (x == HActLast);
        frame_done_d  = running && eof;
        busy_d        = (state_d != StIdle);
        frame_count_d = frame_count_q;
        if (start_acc)         frame_count_d = 8'd0;
        else if (frame_done_d) frame_count_d = frame_count_q + 8'd1;
        // Pattern settings take effect only where the counters wrap to (0,0).
        cfg_d = cfg_q;
        if (start_acc || frame_done_d) begin
            cfg_d = '{pattern: pattern_e'(bus.pattern_sel), const_val: bus.const_val};
        end
        num_frames_d = start_acc ? bus.num_frames : num_frames_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cfg_q         <= '{pattern: PatConst, const_val: 8'd0};
            num_frames_q  <= 8'd0;
            frame_count_q <= 8'd0;
            dout_q        <= 8'd0;
            valid_q       <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cfg_q         <= cfg_d;
            num_frames_q  <= num_frames_d;
            frame_count_q <= frame_count_d;
            dout_q        <= dout_d;
            valid_q       <= valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.valid       = valid_q;
    assign bus.sof         = sof_q;
    assign bus.eol         = eol_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: doc/frame_stream_gen.md
FRAME_STREAM_GEN -- requirements
Module: frame_stream_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_BLANK, default 100, meaning invalid cycles after each line.
REQ-003 The block SHALL have parameter V_ACTIVE, default 600, meaning active lines per frame.
REQ-004 The block SHALL have parameter V_BLANK, default 100, meaning blank lines (H_ACTIVE+H_BLANK cycles each) after each frame.
REQ-005 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin streaming.
- stop  in  1  request to halt at the end of the current frame.
- num_frames  in  8  frames to emit; 0 = continuous.
- pattern_sel  in  2  0 constant, 1 horizontal ramp, 2 vertical ramp, 3 checker.
- const_val  in  8  pixel value for pattern 0.
- dout  out  8  pixel data.
- valid  out  1  dout is an active pixel.
- sof  out  1  marks the first active pixel of a frame.
- eol  out  1  marks the last active pixel of a line.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame, including vertical blank.
- busy  out  1  high while in RUN.
- frame_count  out  8  frames completed since start, wrapping.

Function
REQ-006 The FSM SHALL have states IDLE, RUN and DRAIN; busy SHALL be 1 exactly in RUN and DRAIN.
REQ-007 In IDLE, start=1 SHALL set x=0, y=0, frame_count=0, latch pattern_sel/const_val/num_frames, and enter RUN on the next edge.
REQ-008 In RUN/DRAIN, x SHALL count 0..H_ACTIVE+H_BLANK-1 and wrap to 0; y SHALL increment on each x wrap and wrap to 0 after V_ACTIVE+V_BLANK-1.
REQ-009 All outputs SHALL be registered; the outputs for position (x,y) SHALL appear one cycle after the counters hold (x,y), so the first valid pixel comes 2 edges after start is sampled.
REQ-010 valid SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE; dout SHALL be 0 whenever valid=0.
REQ-011 Pixel value:
- pattern 0: const_val.
- pattern 1: x[7:0].
- pattern 2: y[7:0].
- pattern 3: 8'hFF if x[4]^y[4], else 8'h00.
REQ-012 sof SHALL be 1 only with (x,y)=(0,0); eol SHALL be 1 only with x=H_ACTIVE-1 and y<V_ACTIVE.
REQ-013 frame_done SHALL pulse for the position (H_ACTIVE+H_BLANK-1, V_ACTIVE+V_BLANK-1), and frame_count SHALL increment (mod 256) in the same output cycle.
REQ-014 pattern_sel and const_val SHALL be re-latched only at each frame boundary (x=0,y=0); changes mid-frame SHALL NOT affect the current frame.
REQ-015 stop=1 in RUN SHALL move the FSM to DRAIN; DRAIN SHALL finish the current frame, including blank, then go to IDLE.
REQ-016 If num_frames≠0, the FSM SHALL enter IDLE after the frame whose frame_done makes frame_count equal num_frames.
REQ-017 start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE; if stop and the final-frame condition coincide, the FSM SHALL enter IDLE.
REQ-018 In IDLE, valid, sof, eol, frame_done and dout SHALL be 0; frame_count SHALL hold its value.

Reset
REQ-019 reset=0 at a rising edge SHALL force IDLE, x=y=0, frame_count=0 and all outputs 0, overriding start and stop.
REQ-020 A reset in the middle of a frame SHALL abort the frame immediately, and no frame_done SHALL be emitted for it.

Structure
REQ-021 The pattern encodings, FSM state encodings and default timing constants SHALL reside in a shared package, frame_stream_pkg.
REQ-022 The x/y raster counter SHALL be a sub-module, raster_counter, with inputs clear and enable, outputs x and y, and an end-of-frame flag.

Verification
REQ-023 The bench SHALL run with H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, V_BLANK=1, and SHALL cover:
- Pattern 1, num_frames=1, start: 4 lines of dout 0..7 with valid=1, each followed by 2 cycles with valid=0; then 10 blank cycles; frame_done once; frame_count=1; back in IDLE (50 cycles total).
- Pattern 0, const_val=8'h5A, num_frames=3: exactly 96 valid cycles, all 8'h5A; 3 frame_done pulses; frame_count=3.
- num_frames=0, stop asserted at y=1: the current frame completes, then IDLE; frame_count increments by 1.
- reset=0 at x=3,y=2: next cycle valid=0, busy=0, frame_count=0; no frame_done.
- pattern_sel changed 2→3 mid-frame: the current frame stays a vertical ramp; the next frame's first pixel is 8'h00 and x=16 gives 8'hFF (use H_ACTIVE=32 for this case).
- start pulsed during RUN: no restart; counters continue uninterrupted.
